// File: rtl/onehot_key_encoder.sv
// Debounced one-hot keypad encoder with multi-key lockout and press/release strobes.
// Optional auto-repeat of key_valid is built only when KEY_AUTOREPEAT_EN is defined.
module onehot_key_encoder #(
  parameter int N_KEYS       = 16,
  parameter int CODE_W       = 4,
  parameter int DB_CYCLES    = 1000,
  parameter int REPEAT_DELAY = 50000,
  parameter int REPEAT_RATE  = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] onehot,
  output logic [CODE_W-1:0] binary,
  output logic              key_down,
  output logic              key_valid,
  output logic              key_release,
  output logic              multi_err
);

  localparam int             CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] CLS_ZERO  = 2'd0;
  localparam logic [1:0] CLS_ONE   = 2'd1;
  localparam logic [1:0] CLS_MULTI = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  if ((N_KEYS < 2) || (N_KEYS > 256)) begin : g_bad_n_keys
    $error("onehot_key_encoder: N_KEYS out of range 2..256");
  end
  if (CODE_W < $clog2(N_KEYS)) begin : g_bad_code_w
    $error("onehot_key_encoder: CODE_W too narrow for N_KEYS");
  end
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("onehot_key_encoder: DB_CYCLES must be >= 2");
  end
  if ((REPEAT_DELAY < 2) || (REPEAT_RATE < 2)) begin : g_bad_repeat
    $error("onehot_key_encoder: REPEAT_DELAY and REPEAT_RATE must be >= 2");
  end

  // Population class of a pattern, saturating at two set bits.
  function automatic logic [1:0] classify(input logic [N_KEYS-1:0] v);
    logic [1:0] n;
    n = CLS_ZERO;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i] && (n != CLS_MULTI)) begin
        n = n + 2'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = {CODE_W{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) begin
        idx = CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [N_KEYS-1:0] in_r;
  logic [N_KEYS-1:0] cand_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              fired_r;
  logic              stable_evt_s;
  logic [1:0]        cls_s;
  logic [CODE_W-1:0] enc_s;

  state_t            state_r;
  state_t            state_next_s;
  logic [CODE_W-1:0] binary_next_s;
  logic              valid_next_s;
  logic              release_next_s;
  logic              multi_next_s;
  logic              accept_s;
  logic              repeat_fire_s;

  // fired_r marks that the current candidate has already produced its event
  assign stable_evt_s = (cnt_r == CNT_MAX) && !fired_r;
  assign cls_s        = classify(cand_r);
  assign enc_s        = encode(cand_r);

  // Input capture and debounce counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_r    <= {N_KEYS{1'b0}};
      cand_r  <= {N_KEYS{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      fired_r <= 1'b0;
    end else begin
      in_r <= onehot;
      if (in_r != cand_r) begin
        cand_r  <= in_r;
        cnt_r   <= {CNT_W{1'b0}};
        fired_r <= 1'b0;
      end else begin
        cnt_r   <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        fired_r <= fired_r | stable_evt_s;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DELAY_END = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RATE_END  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_ONE       = RPT_W'(1);

  logic [RPT_W-1:0] rpt_cnt_r;
  logic             rpt_first_r;

  assign repeat_fire_s = (state_r == PRESSED) &&
                         (rpt_cnt_r == (rpt_first_r ? RPT_DELAY_END : RPT_RATE_END));

  // Repeat timer: restarts on every accept, first interval is the long delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_r   <= {RPT_W{1'b0}};
      rpt_first_r <= 1'b1;
    end else if (accept_s) begin
      rpt_cnt_r   <= {RPT_W{1'b0}};
      rpt_first_r <= 1'b1;
    end else if (state_r == PRESSED) begin
      if (repeat_fire_s) begin
        rpt_cnt_r   <= {RPT_W{1'b0}};
        rpt_first_r <= 1'b0;
      end else begin
        rpt_cnt_r   <= rpt_cnt_r + RPT_ONE;
        rpt_first_r <= rpt_first_r;
      end
    end else begin
      rpt_cnt_r   <= {RPT_W{1'b0}};
      rpt_first_r <= 1'b1;
    end
  end
`else
  assign repeat_fire_s = 1'b0;
`endif

  // Next-state and strobe decode; debounce events take priority over repeats.
  always_comb begin
    state_next_s   = state_r;
    binary_next_s  = binary;
    valid_next_s   = 1'b0;
    release_next_s = 1'b0;
    multi_next_s   = 1'b0;
    accept_s       = 1'b0;
    if (stable_evt_s) begin
      case (state_r)
        IDLE: begin
          case (cls_s)
            CLS_ONE: begin
              state_next_s  = PRESSED;
              binary_next_s = enc_s;
              valid_next_s  = 1'b1;
              accept_s      = 1'b1;
            end
            CLS_MULTI: begin
              state_next_s = LOCKOUT;
              multi_next_s = 1'b1;
            end
            default: state_next_s = IDLE;
          endcase
        end
        PRESSED: begin
          case (cls_s)
            CLS_ZERO: begin
              state_next_s   = IDLE;
              release_next_s = 1'b1;
            end
            CLS_ONE: begin
              // a glitch back to the same key is not a new press
              if (enc_s != binary) begin
                binary_next_s = enc_s;
                valid_next_s  = 1'b1;
                accept_s      = 1'b1;
              end else begin
                valid_next_s  = repeat_fire_s;
              end
            end
            CLS_MULTI: begin
              state_next_s = LOCKOUT;
              multi_next_s = 1'b1;
            end
            default: state_next_s = PRESSED;
          endcase
        end
        LOCKOUT: begin
          case (cls_s)
            CLS_ZERO: state_next_s = IDLE;
            default:  state_next_s = LOCKOUT;
          endcase
        end
        default: state_next_s = IDLE;
      endcase
    end else begin
      valid_next_s = repeat_fire_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      binary      <= {CODE_W{1'b0}};
      key_down    <= 1'b0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      multi_err   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      binary      <= binary_next_s;
      key_down    <= (state_next_s == PRESSED);
      key_valid   <= valid_next_s;
      key_release <= release_next_s;
      multi_err   <= multi_next_s;
    end
  end

endmodule

// File: tb/tb_onehot_key_encoder.sv
// Directed bench for onehot_key_encoder (N_KEYS=16, DB_CYCLES=4, repeat 10/3).
module tb_onehot_key_encoder;

  localparam int N  = 16;
  localparam int CW = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  onehot;
  logic [CW-1:0] binary;
  logic          key_down, key_valid, key_release, multi_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid = 0, n_release = 0, n_multi = 0, n_overlap = 0;
  int vq[$];

  onehot_key_encoder #(
    .N_KEYS(N), .CODE_W(CW), .DB_CYCLES(DB), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .rst(rst), .onehot(onehot), .binary(binary), .key_down(key_down),
    .key_valid(key_valid), .key_release(key_release), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin
      n_valid++;
      vq.push_back(cyc);
    end
    if (key_release) n_release++;
    if (multi_err) n_multi++;
    if ((int'(key_valid) + int'(key_release) + int'(multi_err)) > 1) n_overlap++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int vq_at(input int i);
    return (i < vq.size()) ? vq[i] : -1;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_binary"}, 32'(binary), 32'd0);
    check({tag, "_down"}, 32'(key_down), 32'd0);
    check({tag, "_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_release"}, 32'(key_release), 32'd0);
    check({tag, "_multi"}, 32'(multi_err), 32'd0);
  endtask

  initial begin
    int e0, r, bv, br, bm, a;
    rst = 1'b1;
    onehot = '0;
    tick(2);
    check_cleared("reset");
    rst = 1'b0;
    tick(8);

    // 1 press / release
    bv = n_valid; br = n_release;
    onehot = 16'h0020;
    e0 = cyc + 1;
    tick(8);
    check("t1_valid_cnt", n_valid - bv, 1);
    check("t1_valid_edge", vq_at(bv), e0 + 5);
    check("t1_binary", 32'(binary), 5);
    check("t1_down", 32'(key_down), 1);
    onehot = 16'h0000;
    tick(8);
    check("t1_release_cnt", n_release - br, 1);
    check("t1_down_off", 32'(key_down), 0);
    check("t1_binary_hold", 32'(binary), 5);

    // 2 bounce
    bv = n_valid; br = n_release;
    for (int i = 0; i < 10; i++) begin
      onehot = (i % 2 == 0) ? 16'h0080 : 16'h0000;
      tick(2);
    end
    onehot = 16'h0080;
    tick(8);
    check("t2_valid_cnt", n_valid - bv, 1);
    check("t2_binary", 32'(binary), 7);
    check("t2_release_cnt", n_release - br, 0);
    onehot = 16'h0000;
    tick(8);

    // 3 multi-key lockout
    bv = n_valid; br = n_release; bm = n_multi;
    onehot = 16'h0028;
    tick(8);
    check("t3_multi_cnt", n_multi - bm, 1);
    check("t3_valid_cnt", n_valid - bv, 0);
    check("t3_binary_hold", 32'(binary), 7);
    check("t3_down", 32'(key_down), 0);
    onehot = 16'h0000;
    tick(8);
    check("t3_no_release", n_release - br, 0);
    onehot = 16'h0008;
    tick(8);
    check("t3_rearm_valid", n_valid - bv, 1);
    check("t3_rearm_binary", 32'(binary), 3);
    onehot = 16'h0000;
    tick(8);

    // 4 rollover
    bv = n_valid; br = n_release;
    onehot = 16'h0040;
    tick(8);
    check("t4_first_binary", 32'(binary), 6);
    onehot = 16'h2000;
    tick(8);
    check("t4_valid_cnt", n_valid - bv, 2);
    check("t4_binary", 32'(binary), 13);
    check("t4_down", 32'(key_down), 1);
    check("t4_no_release", n_release - br, 0);
    onehot = 16'h0000;
    tick(8);

    // 5 reset mid-press
    onehot = 16'h0400;
    tick(8);
    check("t5_pre_binary", 32'(binary), 10);
    bv = n_valid;
    rst = 1'b1;
    tick(1);
    r = cyc;
    check_cleared("t5_rst");
    rst = 1'b0;
    tick(8);
    check("t5_valid_cnt", n_valid - bv, 1);
    check("t5_valid_edge", vq_at(bv), r + 6);
    check("t5_binary", 32'(binary), 10);
    check("t5_down", 32'(key_down), 1);
    onehot = 16'h0000;
    tick(8);

    // 6 top key, with or without auto-repeat
    bv = n_valid;
    onehot = 16'h8000;
    e0 = cyc + 1;
    a = e0 + 5;
    tick(23);
    check("t6_first_edge", vq_at(bv), a);
    check("t6_binary", 32'(binary), 15);
`ifdef KEY_AUTOREPEAT_EN
    check("t6_valid_cnt", n_valid - bv, 4);
    check("t6_rep1_edge", vq_at(bv + 1), a + 10);
    check("t6_rep2_edge", vq_at(bv + 2), a + 13);
    check("t6_rep3_edge", vq_at(bv + 3), a + 16);
    onehot = 16'h0000;
    tick(10);
`else
    onehot = 16'h0000;
    tick(10);
    check("t6_valid_cnt", n_valid - bv, 1);
`endif
    check("t6_down_off", 32'(key_down), 0);
    check("strobe_overlap", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
